// File: rtl/micro_cpu.sv
// Multi-cycle micro CPU: word-wise code fetch over req/valid, registers, flags, data stack, halt/fault.
// Optional CALL/RET opcodes are enabled by defining MICRO_CPU_CALL_EN.
module micro_cpu #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              code_req,
  output logic [ADDR_W-1:0] code_addr,
  input  logic              code_valid,
  input  logic [DATA_W-1:0] code_data,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned RW  = $clog2(NUM_REGS);
  localparam int unsigned SAW = $clog2(STACK_DEPTH);
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  localparam logic [DATA_W-1:0] OP_NOP  = DATA_W'(8'h00);
  localparam logic [DATA_W-1:0] OP_LDI  = DATA_W'(8'h01);
  localparam logic [DATA_W-1:0] OP_MOV  = DATA_W'(8'h02);
  localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(8'h03);
  localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(8'h04);
  localparam logic [DATA_W-1:0] OP_AND  = DATA_W'(8'h05);
  localparam logic [DATA_W-1:0] OP_OR   = DATA_W'(8'h06);
  localparam logic [DATA_W-1:0] OP_XOR  = DATA_W'(8'h07);
  localparam logic [DATA_W-1:0] OP_CMP  = DATA_W'(8'h08);
  localparam logic [DATA_W-1:0] OP_PUSH = DATA_W'(8'h09);
  localparam logic [DATA_W-1:0] OP_POP  = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(8'h0B);
  localparam logic [DATA_W-1:0] OP_JZ   = DATA_W'(8'h0C);
  localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] OP_CALL = DATA_W'(8'h0E);
  localparam logic [DATA_W-1:0] OP_RET  = DATA_W'(8'h0F);

  typedef enum logic [2:0] {FETCH_OP, FETCH_A, FETCH_B, EXEC, STOP} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   stack [STACK_DEPTH];
  logic [SPW-1:0]      sp, sp_inc, sp_dec;
  logic [DATA_W-1:0]   op, op_a, op_b;
  logic [RW-1:0]       ra, rb;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic [DATA_W:0]     alu_wide;
  logic [2:0]          alu_flags;
  logic                a_bad, b_bad, stk_full, stk_empty, exec_fault, take;

  // Instruction length in words; 0 marks an illegal opcode.
  function automatic logic [1:0] op_words(input logic [DATA_W-1:0] o);
    logic [1:0] w;
    w = 2'd0;
    if (o == OP_NOP || o == OP_HALT) w = 2'd1;
    else if (o >= OP_LDI && o <= OP_CMP) w = 2'd3;
    else if (o >= OP_PUSH && o <= OP_JZ) w = 2'd2;
`ifdef MICRO_CPU_CALL_EN
    else if (o == OP_CALL) w = 2'd2;
    else if (o == OP_RET) w = 2'd1;
`endif
    return w;
  endfunction

  assign code_req  = (state == FETCH_OP || state == FETCH_A || state == FETCH_B) && !reset;
  assign code_addr = pc;
  assign take      = code_req && code_valid;
  assign ra        = op_a[RW-1:0];
  assign rb        = op_b[RW-1:0];
  assign rd_val    = regs[ra];
  assign rs_val    = regs[rb];
  assign a_bad     = op_a >= DATA_W'(NUM_REGS);
  assign b_bad     = op_b >= DATA_W'(NUM_REGS);
  assign sp_inc    = sp + SPW'(1);
  assign sp_dec    = sp - SPW'(1);
  assign stk_full  = sp == SPW'(STACK_DEPTH);
  assign stk_empty = sp == '0;
  assign alu_flags = {alu_wide[DATA_W-1], alu_wide[DATA_W], ~|alu_wide[DATA_W-1:0]};

  always_comb begin
    dbg_data = '0;
    if (32'(dbg_sel) < NUM_REGS) dbg_data = regs[dbg_sel[RW-1:0]];
  end

  always_comb begin
    alu_wide   = '0;
    exec_fault = 1'b0;
    case (op)
      OP_LDI:                       exec_fault = a_bad;
      OP_MOV:                       exec_fault = a_bad || b_bad;
      OP_ADD: begin
        exec_fault = a_bad || b_bad;
        alu_wide   = {1'b0, rd_val} + {1'b0, rs_val};
      end
      OP_SUB, OP_CMP: begin
        exec_fault = a_bad || b_bad;
        alu_wide   = {1'b0, rd_val} - {1'b0, rs_val};
      end
      OP_AND: begin exec_fault = a_bad || b_bad; alu_wide = {1'b0, rd_val & rs_val}; end
      OP_OR:  begin exec_fault = a_bad || b_bad; alu_wide = {1'b0, rd_val | rs_val}; end
      OP_XOR: begin exec_fault = a_bad || b_bad; alu_wide = {1'b0, rd_val ^ rs_val}; end
      OP_PUSH:                      exec_fault = a_bad || stk_full;
      OP_POP:                       exec_fault = a_bad || stk_empty;
`ifdef MICRO_CPU_CALL_EN
      OP_CALL:                      exec_fault = stk_full;
      OP_RET:                       exec_fault = stk_empty;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH_OP: if (take) begin
        case (op_words(code_data))
          2'd0:    state_n = STOP;
          2'd1:    state_n = EXEC;
          default: state_n = FETCH_A;
        endcase
      end
      FETCH_A:  if (take) state_n = (op_words(op) == 2'd3) ? FETCH_B : EXEC;
      FETCH_B:  if (take) state_n = EXEC;
      EXEC:     state_n = (exec_fault || op == OP_HALT) ? STOP : FETCH_OP;
      default:  state_n = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_OP;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      flags  <= '0;
      sp     <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
      op     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH_OP: if (take) begin
          op <= code_data;
          pc <= pc + ADDR_W'(1);
          if (op_words(code_data) == 2'd0) begin
            fault  <= 1'b1;
            halted <= 1'b1;
          end
        end
        FETCH_A: if (take) begin op_a <= code_data; pc <= pc + ADDR_W'(1); end
        FETCH_B: if (take) begin op_b <= code_data; pc <= pc + ADDR_W'(1); end
        EXEC: begin
          if (exec_fault) begin
            fault  <= 1'b1;
            halted <= 1'b1;
          end else begin
            case (op)
              OP_LDI: regs[ra] <= op_b;
              OP_MOV: regs[ra] <= rs_val;
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                regs[ra] <= alu_wide[DATA_W-1:0];
                flags    <= alu_flags;
              end
              OP_CMP: flags <= alu_flags;
              OP_PUSH: begin stack[sp[SAW-1:0]] <= rd_val; sp <= sp_inc; end
              OP_POP:  begin regs[ra] <= stack[sp_dec[SAW-1:0]]; sp <= sp_dec; end
              OP_JMP:  pc <= op_a[ADDR_W-1:0];
              OP_JZ:   if (flags[0]) pc <= op_a[ADDR_W-1:0];
              OP_HALT: halted <= 1'b1;
`ifdef MICRO_CPU_CALL_EN
              OP_CALL: begin
                stack[sp[SAW-1:0]] <= DATA_W'(pc);
                sp <= sp_inc;
                pc <= op_a[ADDR_W-1:0];
              end
              OP_RET: begin
                pc <= stack[sp_dec[SAW-1:0]][ADDR_W-1:0];
                sp <= sp_dec;
              end
`endif
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
